arm_sim_memory: RTL

Parametrised simulation memory slave for the arm7tdmi_top memory port. It replaces the fixed always-ready, constant-NOP stub used in the core benches. It provides a word-organised RAM with byte-lane writes and configurable non-sequential and sequential wait states. It also flags out-of-range accesses and protocol violations, and counts completed accesses.

---
 rtl/arm_sim_memory.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arm_sim_memory.sv
`default_nettype none
// ============================================================================
// Module  : arm_sim_memory
// Purpose : Simulation memory slave for the arm7tdmi_top memory port.
//           Word-organised RAM with byte-lane writes and separate wait-state
//           counts for non-sequential and sequential accesses. Flags
//           out-of-range addresses and protocol violations (sticky), and
//           counts completed accesses.
// Ports   : clk, rst_n        clock, async active-low reset
//           mem_addr/wdata    byte address ([1:0] ignored) and write data
//           mem_we/re/be      write/read requests, little-endian byte enables
//           mem_rdata/ready   read data (valid while ready on a read), completion
//           err_oob/err_proto sticky error flags
//           access_cnt        completed accesses since reset
// Revision: 1.0 - initial release
// ============================================================================
module arm_sim_memory #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          N_WAIT     = 0,
    parameter int          S_WAIT     = 0,
    parameter logic [31:0] FILL_WORD  = 32'hE1A00000,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        err_oob,
    output logic        err_proto,
    output logic [31:0] access_cnt
);

    localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] C_N_WAIT = 4'(N_WAIT);
    localparam logic [3:0] C_S_WAIT = 4'(S_WAIT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_valid_q, last_valid_d;
    logic [29:0] last_word_q, last_word_d;
    // Address/direction captured when a wait starts, used to catch a master
    // that changes its request mid-wait.
    logic [29:0] hold_word_q, hold_word_d;
    logic        hold_we_q, hold_we_d;
    logic        err_oob_q, err_oob_d;
    logic        err_proto_q, err_proto_d;
    logic [31:0] access_cnt_q, access_cnt_d;

    logic [31:0] mem_q [DEPTH];

    logic                  w_req;
    logic [29:0]           w_word;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic                  w_oob;
    logic                  w_seq;
    logic [3:0]            w_wait;
    logic                  w_viol;
    logic                  w_ready;
    logic                  w_commit;
    logic                  w_wr_en;

    // Simulation image: every word starts at the fill value.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = FILL_WORD;
    end

    always_comb begin
        w_req  = mem_we | mem_re;
        w_word = mem_addr[31:2];
        w_idx  = mem_addr[ADDR_WIDTH-1:2];
        w_oob  = (mem_addr >> ADDR_WIDTH) != 32'd0;
        w_seq  = last_valid_q && (w_word == last_word_q + 30'd1);
        w_wait = w_seq ? C_S_WAIT : C_N_WAIT;
        w_viol = (state_q == ST_WAIT) &&
                 (!w_req || (w_word != hold_word_q) || (mem_we != hold_we_q));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_valid_d = last_valid_q;
        last_word_d  = last_word_q;
        hold_word_d  = hold_word_q;
        hold_we_d    = hold_we_q;
        err_oob_d    = err_oob_q;
        err_proto_d  = err_proto_q;
        access_cnt_d = access_cnt_q;
        w_ready      = 1'b0;
        w_commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_req) begin
                    w_ready = 1'b1;
                end else if (w_wait == 4'd0) begin
                    w_ready  = 1'b1;
                    w_commit = 1'b1;
                end else begin
                    state_d     = ST_WAIT;
                    cnt_d       = w_wait - 4'd1;
                    hold_word_d = w_word;
                    hold_we_d   = mem_we;
                end
            end
            ST_WAIT: begin
                if (w_viol) begin
                    // Abandoned or altered request: abort without committing.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    w_ready  = 1'b1;
                    w_commit = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_commit) begin
            last_valid_d = 1'b1;
            last_word_d  = w_word;
            access_cnt_d = access_cnt_q + 32'd1;
            if (w_oob) err_oob_d = 1'b1;
        end

        // Simultaneous read+write is served as a write but still flagged.
        if ((mem_we && mem_re) || w_viol) err_proto_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_valid_q <= 1'b0;
            last_word_q  <= 30'd0;
            hold_word_q  <= 30'd0;
            hold_we_q    <= 1'b0;
            err_oob_q    <= 1'b0;
            err_proto_q  <= 1'b0;
            access_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_valid_q <= last_valid_d;
            last_word_q  <= last_word_d;
            hold_word_q  <= hold_word_d;
            hold_we_q    <= hold_we_d;
            err_oob_q    <= err_oob_d;
            err_proto_q  <= err_proto_d;
            access_cnt_q <= access_cnt_d;
        end
    end

    // Reset gates the write so an access can never land while held in reset.
    assign w_wr_en = w_commit && mem_we && !w_oob && rst_n;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem_q[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign mem_rdata  = (w_commit && !mem_we && !w_oob) ? mem_q[w_idx] : 32'd0;
    assign mem_ready  = w_ready;
    assign err_oob    = err_oob_q;
    assign err_proto  = err_proto_q;
    assign access_cnt = access_cnt_q;

endmodule
`default_nettype wire
